// File: rtl/execute_skid_stage.sv
// Two-entry skid buffer between decode and execute; in_ready is registered so
// backpressure never forms a combinational path from downstream.
module execute_skid_stage #(
  parameter int                 INSTR_W = 32,
  parameter int                 PC_W    = 7,
  parameter int                 CNT_W   = 8,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(32'hE320F000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               branch_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               branch_out,
  output logic [3:0]         cond,
  output logic [3:0]         rn,
  output logic [3:0]         rs,
  output logic [3:0]         rm,
  output logic [4:0]         imm5,
  output logic [CNT_W-1:0]   stall_cnt
);

  // State encoding is {SKID.valid, HEAD.valid}; 2'b10 cannot occur.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               r_headValid;
  logic [INSTR_W-1:0] r_headInstr;
  logic [PC_W-1:0]    r_headPc;
  logic               r_headBranch;
  logic               r_skidValid;
  logic [INSTR_W-1:0] r_skidInstr;
  logic [PC_W-1:0]    r_skidPc;
  logic               r_skidBranch;
  logic [CNT_W-1:0]   r_stallCnt;

  logic [1:0]         w_state;
  logic               w_inXfer;
  logic               w_outXfer;
  logic               w_stalled;

  assign w_state   = {r_skidValid, r_headValid};
  assign w_inXfer  = in_valid & ~r_skidValid;
  assign w_outXfer = r_headValid & out_ready;
  assign w_stalled = r_headValid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_headValid  <= 1'b0;
      r_headInstr  <= NOP;
      r_headPc     <= '0;
      r_headBranch <= 1'b0;
      r_skidValid  <= 1'b0;
      r_skidInstr  <= NOP;
      r_skidPc     <= '0;
      r_skidBranch <= 1'b0;
    end else if (flush) begin
      r_headValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else begin
      case (w_state)
        EMPTY: begin
          if (w_inXfer) begin
            r_headValid  <= 1'b1;
            r_headInstr  <= instr_in;
            r_headPc     <= pc_in;
            r_headBranch <= branch_in;
          end
        end
        ONE: begin
          if (w_inXfer && w_outXfer) begin
            r_headInstr  <= instr_in;
            r_headPc     <= pc_in;
            r_headBranch <= branch_in;
          end else if (w_outXfer) begin
            r_headValid <= 1'b0;
          end else if (w_inXfer) begin
            r_skidValid  <= 1'b1;
            r_skidInstr  <= instr_in;
            r_skidPc     <= pc_in;
            r_skidBranch <= branch_in;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain into HEAD can happen.
          if (w_outXfer) begin
            r_headInstr  <= r_skidInstr;
            r_headPc     <= r_skidPc;
            r_headBranch <= r_skidBranch;
            r_skidValid  <= 1'b0;
          end
        end
        default: begin
          r_headValid <= 1'b0;
          r_skidValid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (flush) begin
      r_stallCnt <= '0;
    end else if (w_stalled && (r_stallCnt != CNT_MAX)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign in_ready   = ~r_skidValid;
  assign out_valid  = r_headValid;
  assign instr_out  = r_headValid ? r_headInstr : NOP;
  assign pc_out     = r_headValid ? r_headPc : '0;
  assign branch_out = r_headValid & r_headBranch;
  assign stall_cnt  = r_stallCnt;

  assign cond = instr_out[31:28];
  assign rn   = instr_out[19:16];
  assign rs   = instr_out[11:8];
  assign rm   = instr_out[3:0];
  assign imm5 = instr_out[11:7];

endmodule

// File: tb/tb_execute_skid_stage.sv
// Directed bench for execute_skid_stage: streaming, backpressure, stall
// saturation, flush, field decode and asynchronous reset.
module tb_execute_skid_stage;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 7;
  localparam int CNT_W   = 8;
  localparam logic [31:0] NOP_I = 32'hE320F000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic               branch_in;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic               branch_out;
  logic [3:0]         cond, rn, rs, rm;
  logic [4:0]         imm5;
  logic [CNT_W-1:0]   stall_cnt;

  int total = 0;
  int bad   = 0;

  execute_skid_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .branch_in(branch_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .branch_out(branch_out),
    .cond(cond), .rn(rn), .rs(rs), .rm(rm), .imm5(imm5),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr_in  = '0;
    pc_in     = '0;
    branch_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    out_ready = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (instr_out !== NOP_I) begin bad++; $display("[TB] FAIL reset_instr got=%h want=%h", instr_out, NOP_I); end
    total++; if (pc_out !== 7'd0 || branch_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_pc_branch got=%0d/%0b want=0/0", pc_out, branch_out); end
    total++; if (cond !== 4'hE) begin bad++; $display("[TB] FAIL reset_cond got=%h want=e", cond); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_stall got=%0d want=0", stall_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid  = 1'b1;
      pc_in     = PC_W'(i);
      instr_in  = 32'hA0000000 + 32'(i);
      branch_in = (i == 3);
      tick();
      total++; if (out_valid !== 1'b1 || pc_out !== PC_W'(i)) begin bad++; $display("[TB] FAIL stream_pc%0d got=%0b/%0d want=1/%0d", i, out_valid, pc_out, i); end
      total++; if (instr_out !== 32'hA0000000 + 32'(i) || branch_out !== (i == 3)) begin bad++; $display("[TB] FAIL stream_data%0d got=%h/%0b", i, instr_out, branch_out); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready%0d got=%0b want=1", i, in_ready); end
    end
    idleInputs();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drain got=%0b want=0", out_valid); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("[TB] FAIL stream_stall got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pc_in     = 7'd10;
    tick();
    total++; if (pc_out !== 7'd10 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_first got=%0d/%0b want=10/1", pc_out, in_ready); end
    pc_in = 7'd11;
    tick();
    total++; if (in_ready !== 1'b0 || pc_out !== 7'd10) begin bad++; $display("[TB] FAIL bp_full got=%0b/%0d want=0/10", in_ready, pc_out); end
    pc_in = 7'd12;
    tick();
    total++; if (in_ready !== 1'b0 || pc_out !== 7'd10) begin bad++; $display("[TB] FAIL bp_hold got=%0b/%0d want=0/10", in_ready, pc_out); end
    out_ready = 1'b1;
    tick();
    total++; if (pc_out !== 7'd11 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain11 got=%0d/%0b want=11/1", pc_out, in_ready); end
    tick();
    total++; if (pc_out !== 7'd12 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain12 got=%0d/%0b want=12/1", pc_out, out_valid); end
    idleInputs();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%0b want=0", out_valid); end
    total++; if (stall_cnt !== 8'd2) begin bad++; $display("[TB] FAIL bp_stall got=%0d want=2", stall_cnt); end
  endtask

  task automatic test_stall_saturate();
    out_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b1;
    pc_in    = 7'd20;
    tick();
    in_valid = 1'b0;
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("[TB] FAIL stall_start got=%0d want=0", stall_cnt); end
    for (int i = 0; i < 10; i++) tick();
    total++; if (stall_cnt !== 8'd10) begin bad++; $display("[TB] FAIL stall_ten got=%0d want=10", stall_cnt); end
    for (int i = 0; i < 290; i++) tick();
    total++; if (stall_cnt !== 8'd255) begin bad++; $display("[TB] FAIL stall_sat got=%0d want=255", stall_cnt); end
  endtask

  task automatic test_flush();
    // HEAD still holds pc 20 from the stall test; add one to fill SKID.
    in_valid = 1'b1;
    pc_in    = 7'd21;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_prefull got=%0b want=0", in_ready); end
    flush = 1'b1;
    pc_in = 7'd99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || instr_out !== NOP_I) begin bad++; $display("[TB] FAIL flush_out got=%0b/%h want=0/%h", out_valid, instr_out, NOP_I); end
    total++; if (in_ready !== 1'b1 || stall_cnt !== 8'd0) begin bad++; $display("[TB] FAIL flush_state got=%0b/%0d want=1/0", in_ready, stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_leak got=%0b/%0d want=0", out_valid, pc_out); end
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'hE0812003;
    pc_in     = 7'd30;
    tick();
    in_valid = 1'b0;
    total++; if ({cond, rn, rs, rm} !== 16'hE103 || imm5 !== 5'd0) begin bad++; $display("[TB] FAIL decode_add got=%h/%0d want=e103/0", {cond, rn, rs, rm}, imm5); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr_in  = 32'h00000F80;
    tick();
    in_valid = 1'b0;
    total++; if (imm5 !== 5'd31 || rs !== 4'hF || cond !== 4'h0) begin bad++; $display("[TB] FAIL decode_imm got=%0d/%h/%h want=31/f/0", imm5, rs, cond); end
    tick();
    total++; if (cond !== 4'hE || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL decode_nop got=%h/%0b want=e/0", cond, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pc_in     = 7'd40;
    instr_in  = 32'h11111111;
    tick();
    pc_in = 7'd41;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL areset_prefull got=%0b/%0b want=0/1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== NOP_I) begin bad++; $display("[TB] FAIL areset_now got=%0b/%0b/%h want=0/1/%h", out_valid, in_ready, instr_out, NOP_I); end
    total++; if (pc_out !== 7'd0 || stall_cnt !== 8'd0 || cond !== 4'hE) begin bad++; $display("[TB] FAIL areset_vals got=%0d/%0d/%h want=0/0/e", pc_out, stall_cnt, cond); end
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_after got=%0b/%0d want=0", out_valid, pc_out); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall_saturate();
    test_flush();
    test_decode();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
